// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind the UART receiver: FWFT buffer with 16750-style status.
// Optional character timeout is built only when UART_RX_FIFO_TIMEOUT_EN is defined.
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          RXCLK,
  input  logic          CLEAR,
  input  logic          FIFOEN,
  input  logic [1:0]    WLS,
  input  logic          STB,
  input  logic          PEN,
  input  logic [1:0]    TRIG,
  input  logic          RXFINISHED,
  input  logic [7:0]    DIN,
  input  logic          PE_IN,
  input  logic          FE_IN,
  input  logic          BI_IN,
  input  logic          READ,
  input  logic          OE_CLR,
  output logic [7:0]    DOUT,
  output logic          PE,
  output logic          FE,
  output logic          BI,
  output logic          EMPTY,
  output logic          FULL,
  output logic [AW:0]   USAGE,
  output logic          TRIGGER,
  output logic          OVERRUN,
  output logic          FIFOERR,
  output logic          TIMEOUT
);

  localparam logic [AW:0] CAP_FIFO = (AW+1)'(DEPTH);
  localparam logic [AW:0] LVL_ONE  = (AW+1)'(1);
  localparam logic [AW:0] LVL_QTR  = (AW+1)'(DEPTH / 4);
  localparam logic [AW:0] LVL_HALF = (AW+1)'(DEPTH / 2);
  localparam logic [AW:0] LVL_HIGH = (AW+1)'(DEPTH - 2);

  logic [10:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_usage;
  logic [AW:0]   r_err_cnt;
  logic          r_overrun;
  logic          r_fifoen_d;

  logic [AW:0]   w_cap;
  logic [AW:0]   w_trig_lvl;
  logic          w_empty;
  logic          w_full;
  logic          w_flush;
  logic          w_wr;
  logic          w_pop;
  logic          w_acc;
  logic          w_ovr_set;
  logic          w_overwrite;
  logic [10:0]   w_new;
  logic [10:0]   w_head;
  logic          w_new_err;
  logic          w_head_err;
  logic [AW-1:0] w_wr_addr;

  assign w_cap      = FIFOEN ? CAP_FIFO : LVL_ONE;
  assign w_empty    = (r_usage == '0);
  assign w_full     = (r_usage == w_cap);
  // Toggling FIFOEN flushes for one cycle, just like CLEAR.
  assign w_flush    = CLEAR | (FIFOEN != r_fifoen_d);
  assign w_wr       = RXFINISHED & ~w_flush;
  assign w_pop      = READ & ~w_empty & ~w_flush;
  assign w_acc      = w_wr & (~w_full | w_pop);
  assign w_ovr_set  = w_wr & w_full & ~w_pop;
  assign w_overwrite = w_ovr_set & ~FIFOEN;

  assign w_new      = {BI_IN, FE_IN, PE_IN, DIN};
  assign w_new_err  = BI_IN | FE_IN | PE_IN;
  assign w_head     = r_mem[r_rd_ptr];
  assign w_head_err = |w_head[10:8];
  // In 16450 mode an overrun replaces the single held character in place.
  assign w_wr_addr  = w_overwrite ? r_rd_ptr : r_wr_ptr;

  always_ff @(posedge CLK) begin
    if (w_acc || w_overwrite) begin
      r_mem[w_wr_addr] <= w_new;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_usage    <= '0;
      r_fifoen_d <= 1'b0;
    end else begin
      r_fifoen_d <= FIFOEN;
      if (w_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_usage  <= '0;
      end else begin
        if (w_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
        case ({w_acc, w_pop})
          2'b10:   r_usage <= r_usage + 1'b1;
          2'b01:   r_usage <= r_usage - 1'b1;
          default: r_usage <= r_usage;
        endcase
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_err_cnt <= '0;
    end else if (w_flush) begin
      r_err_cnt <= '0;
    end else if (w_overwrite) begin
      r_err_cnt <= {{AW{1'b0}}, w_new_err};
    end else begin
      case ({w_acc & w_new_err, w_pop & w_head_err})
        2'b10:   r_err_cnt <= r_err_cnt + 1'b1;
        2'b01:   r_err_cnt <= r_err_cnt - 1'b1;
        default: r_err_cnt <= r_err_cnt;
      endcase
    end
  end

  // A new overrun wins over a same-cycle LSR read.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_overrun <= 1'b0;
    end else if (w_ovr_set) begin
      r_overrun <= 1'b1;
    end else if (OE_CLR) begin
      r_overrun <= 1'b0;
    end
  end

  always_comb begin
    w_trig_lvl = LVL_ONE;
    if (FIFOEN) begin
      case (TRIG)
        2'b00:   w_trig_lvl = LVL_ONE;
        2'b01:   w_trig_lvl = LVL_QTR;
        2'b10:   w_trig_lvl = LVL_HALF;
        default: w_trig_lvl = LVL_HIGH;
      endcase
    end
  end

`ifdef UART_RX_FIFO_TIMEOUT_EN
  logic [9:0] r_to_cnt;
  logic       r_timeout;
  logic [3:0] w_char_len;
  logic [9:0] w_to_limit;
  logic       w_to_clr;

  // start + data + parity + stop bits; limit is four characters of 16 ticks
  assign w_char_len = 4'd7 + {2'b00, WLS} + {3'b000, PEN} + {3'b000, STB};
  assign w_to_limit = {w_char_len, 6'b000000};
  assign w_to_clr   = w_acc | w_pop | w_flush | w_overwrite | w_empty;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_to_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (w_to_clr) begin
        r_to_cnt <= '0;
      end else if (RXCLK && (r_to_cnt < w_to_limit)) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
      r_timeout <= FIFOEN & ~w_to_clr & (r_to_cnt >= w_to_limit);
    end
  end

  assign TIMEOUT = r_timeout;
`else
  logic w_unused_to;
  assign w_unused_to = ^{RXCLK, WLS, STB, PEN};
  assign TIMEOUT     = 1'b0;
`endif

  assign EMPTY   = w_empty;
  assign FULL    = w_full;
  assign USAGE   = r_usage;
  assign TRIGGER = (r_usage >= w_trig_lvl);
  assign OVERRUN = r_overrun;
  assign FIFOERR = (r_err_cnt != '0);
  assign DOUT    = w_empty ? 8'h00 : w_head[7:0];
  assign PE      = ~w_empty & w_head[8];
  assign FE      = ~w_empty & w_head[9];
  assign BI      = ~w_empty & w_head[10];

endmodule
